// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared fetch state encoding and PC constants
package fetch_pc_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;
  localparam int PC_INCR = 4;
  localparam int INSTR_W_DEF = 32;
endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// next_pc_calc: combinational branch resolution and next-PC selection
module next_pc_calc import fetch_pc_unit_pkg::*; #(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] imm_i,
  input  logic            uncond_i,
  input  logic            branch_i,
  input  logic            branch_nz_i,
  input  logic            zero_i,
  output logic [PC_W-1:0] next_pc_o
);
  logic taken;
  assign taken = uncond_i | (branch_i & zero_i) | (branch_nz_i & ~zero_i);
  assign next_pc_o = pc_i + (taken ? imm_i << 2 : PC_W'(PC_INCR));
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC owner issuing one fetch at a time and handing instructions to decode
module fetch_pc_unit import fetch_pc_unit_pkg::*; #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [PC_W-1:0]    StartPC,
  output logic               IMemReqValid,
  input  logic               IMemReqReady,
  output logic [PC_W-1:0]    IMemAddr,
  input  logic               IMemRespValid,
  input  logic [INSTR_W-1:0] IMemRespData,
  output logic [INSTR_W-1:0] Instruction,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [PC_W-1:0]    PC,
  input  logic [PC_W-1:0]    BusImm,
  input  logic               Uncondbranch,
  input  logic               Branch,
  input  logic               BranchNZ,
  input  logic               ALUZero,
  output logic [CNT_W-1:0]   FetchCount
);
  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_q, vld_q;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc_i       (pc_q),
    .imm_i      (BusImm),
    .uncond_i   (Uncondbranch),
    .branch_i   (Branch),
    .branch_nz_i(BranchNZ),
    .zero_i     (ALUZero),
    .next_pc_o  (pc_d)
  );

  // req_q/vld_q track REQ/HOLD so both strobes come straight from flops
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pc_q    <= StartPC;
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: if (IMemReqReady) begin
          state_q <= WAIT;
          req_q   <= 1'b0;
        end
        WAIT: if (IMemRespValid) begin
          instr_q <= IMemRespData;
          state_q <= HOLD;
          vld_q   <= 1'b1;
        end
        HOLD: if (InstrReady) begin
          pc_q    <= pc_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= REQ;
          vld_q   <= 1'b0;
          req_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IMemReqValid = req_q;
  assign IMemAddr     = pc_q;
  assign PC           = pc_q;
  assign Instruction  = instr_q;
  assign InstrValid   = vld_q;
  assign FetchCount   = cnt_q;
endmodule
